// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter slice.
//   UART_BYTE_W : width of one transmitted byte
//   arb_state_e : arbiter FSM state encoding (2 bits)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_ARB       = 2'd0,  // choose the next byte (or wait for the lock owner)
        ST_ISSUE     = 2'd1,  // start pulse to the transmitter
        ST_WAIT_BUSY = 2'd2,  // wait for the transmitter to acknowledge with busy
        ST_WAIT_IDLE = 2'd3   // wait for the frame to finish
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector.
//   req_i   : request vector, one bit per requester
//   ptr_i   : index that has highest priority when unlocked
//   lock_i  : when set only owner_i may be picked
//   owner_i : current packet owner
//   pick_o  : one-hot selected requester, zero when nothing selectable
//   idx_o   : index of pick_o (zero when pick_o is zero)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             lock_i,
    input  logic [IDX_W-1:0] owner_i,
    output logic [N_REQ-1:0] pick_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
        pick_o = '0;
        idx_o  = '0;
        if (lock_i) begin
            // A locked packet stalls everyone else until its owner continues.
            if (req_i[owner_i]) begin
                pick_o[owner_i] = 1'b1;
                idx_o           = owner_i;
            end
        end else begin
            // Scan from farthest to nearest so the last hit kept is the first
            // valid requester at or after ptr_i (modulo N_REQ).
            for (int k = N_REQ - 1; k >= 0; k--) begin
                if (req_i[(int'(ptr_i) + k) % N_REQ]) begin
                    pick_o = '0;
                    pick_o[(int'(ptr_i) + k) % N_REQ] = 1'b1;
                    idx_o  = IDX_W'((int'(ptr_i) + k) % N_REQ);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one byte-wide UART transmitter among N_REQ byte-stream requesters with
// round-robin arbitration and packet lock (a packet is never interleaved).
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_req_valid  : requester r offers a byte
//   i_req_data   : byte of requester r in bits [8r+7:8r]
//   i_req_last   : offered byte closes its packet
//   o_req_ready  : byte of requester r taken this cycle (one-hot or zero)
//   o_grant      : one-hot current owner, zero when unowned
//   o_tx_data    : byte to the transmitter, stable from ISSUE to next accept
//   o_tx_start   : one-cycle start pulse to the transmitter
//   i_tx_busy    : transmitter busy flag
//   o_busy       : arbiter holds a byte or a packet lock
//   o_err        : sticky, transmitter never went busy after a start
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int BUSY_TO = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             i_req_valid,
    input  logic [UART_BYTE_W*N_REQ-1:0] i_req_data,
    input  logic [N_REQ-1:0]             i_req_last,
    output logic [N_REQ-1:0]             o_req_ready,
    output logic [N_REQ-1:0]             o_grant,
    output logic [UART_BYTE_W-1:0]       o_tx_data,
    output logic                         o_tx_start,
    input  logic                         i_tx_busy,
    output logic                         o_busy,
    output logic                         o_err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(BUSY_TO + 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    arb_state_e             state_q;
    logic [IDX_W-1:0]       owner_q;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic                   lock_q;
    logic                   last_q;
    logic                   tx_start_q;
    logic                   err_q;
    logic [UART_BYTE_W-1:0] tx_data_q;
    logic [CNT_W-1:0]       cnt_q;

    logic [N_REQ-1:0]       pick;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W-1:0]       next_ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (i_req_valid),
        .ptr_i   (rr_ptr_q),
        .lock_i  (lock_q),
        .owner_i (owner_q),
        .pick_o  (pick),
        .idx_o   (pick_idx)
    );

    // Priority moves to the requester after the one just served, wrapping.
    assign next_ptr = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    // Ready is combinational so a byte is taken in the same cycle it is chosen.
    assign o_req_ready = (state_q == ST_ARB) ? pick : '0;
    assign o_grant     = ((state_q != ST_ARB) || lock_q) ? (ONE_HOT0 << owner_q) : '0;
    assign o_busy      = (state_q != ST_ARB) || lock_q;
    assign o_tx_data   = tx_data_q;
    assign o_tx_start  = tx_start_q;
    assign o_err       = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ARB;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            last_q     <= 1'b0;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
            tx_data_q  <= '0;
            cnt_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments only, so every register sees pre-edge values.
            tx_start_q <= 1'b0;
            case (state_q)
                ST_ARB: begin
                    if (|pick) begin
                        owner_q    <= pick_idx;
                        tx_data_q  <= i_req_data[32'(pick_idx) * UART_BYTE_W +: UART_BYTE_W];
                        last_q     <= i_req_last[pick_idx];
                        tx_start_q <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        state_q <= ST_WAIT_IDLE;
                    end else if (cnt_q == CNT_W'(BUSY_TO - 1)) begin
                        // Transmitter ignored the start: drop the packet, flag it.
                        err_q    <= 1'b1;
                        lock_q   <= 1'b0;
                        rr_ptr_q <= next_ptr;
                        state_q  <= ST_ARB;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_IDLE: begin
                    if (!i_tx_busy) begin
                        state_q <= ST_ARB;
                        if (last_q) begin
                            lock_q   <= 1'b0;
                            rr_ptr_q <= next_ptr;
                        end else begin
                            lock_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (N_REQ=4, BUSY_TO=8) with a behavioural
// byte transmitter (4 clocks per bit) and a line decoder.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N       = 4;
    localparam int BUSY_TO = 8;
    localparam int NCLKS   = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [7:0] gap;
    } item_t;

    typedef struct {
        int         r;
        logic [7:0] data;
        logic [3:0] exp_grant;
        logic [7:0] exp_byte;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0] req_last = '0;
    logic [N-1:0] req_ready;
    logic [N-1:0] grant;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         tx_busy;
    logic         busy;
    logic         err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ   (N),
        .BUSY_TO (BUSY_TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_grant     (grant),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .i_tx_busy   (tx_busy),
        .o_busy      (busy),
        .o_err       (err)
    );

    // ---------------- behavioural transmitter ----------------
    logic       stub_mode = 1'b0;  // when set the transmitter ignores starts
    logic       tx_line;
    logic [9:0] tx_sh;
    int         tx_bit;
    int         tx_div;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy <= 1'b0;
            tx_line <= 1'b1;
            tx_sh   <= '1;
            tx_bit  <= 0;
            tx_div  <= 0;
        end else if (!tx_busy) begin
            if (tx_start && !stub_mode) begin
                tx_busy <= 1'b1;
                tx_sh   <= {1'b1, tx_data, 1'b0};
                tx_line <= 1'b0;
                tx_bit  <= 0;
                tx_div  <= 0;
            end
        end else if (tx_div == NCLKS - 1) begin
            tx_div <= 0;
            if (tx_bit == 9) begin
                tx_busy <= 1'b0;
                tx_line <= 1'b1;
            end else begin
                tx_bit  <= tx_bit + 1;
                tx_line <= tx_sh[tx_bit + 1];
            end
        end else begin
            tx_div <= tx_div + 1;
        end
    end

    // ---------------- bookkeeping ----------------
    int         n_checks = 0;
    int         n_errors = 0;
    item_t      src_q [N][$];
    logic [N-1:0] started = '0;
    int         wait_cnt [N];
    logic [N-1:0] hs = '0;

    logic [7:0] rx_q [$];
    logic [3:0] grant_log [$];
    logic [3:0] last_grant = '0;
    logic [9:0] rx_bits = '0;
    logic [9:0] last_frame = '0;
    int         rx_cnt = 0;
    int         ready_n [N];
    int         starts_n = 0;
    int         busy_viol = 0;
    int         order_bad = 0;
    int         obusy_falls = 0;
    logic       prev_obusy = 1'b0;
    logic       prev_txbusy = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] get_rx(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 8'hxx;
    endfunction

    function automatic logic [3:0] get_grant(input int i);
        if (i < grant_log.size()) return grant_log[i];
        return 4'hx;
    endfunction

    function automatic bit src_empty();
        for (int r = 0; r < N; r++)
            if (src_q[r].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push(input int r, input logic [7:0] d, input logic l, input int gap);
        item_t it;
        it.data = d;
        it.last = l;
        it.gap  = 8'(gap);
        src_q[r].push_back(it);
    endtask

    task automatic clear_mon();
        rx_q.delete();
        grant_log.delete();
        last_grant  = '0;
        starts_n    = 0;
        busy_viol   = 0;
        order_bad   = 0;
        obusy_falls = 0;
        for (int r = 0; r < N; r++) ready_n[r] = 0;
    endtask

    task automatic flush_sources();
        for (int r = 0; r < N; r++) src_q[r].delete();
        started   = '0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        repeat (3) @(negedge clk);
        while (!(busy == 1'b0 && tx_busy == 1'b0 && src_empty() && req_valid == '0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, 32'(n < budget), 32'd1);
    endtask

    // Requester sources: present the head of each queue, pop on handshake.
    initial begin
        for (int r = 0; r < N; r++) wait_cnt[r] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int r = 0; r < N; r++) begin
                if (!rst_n) begin
                    src_q[r].delete();
                    started[r] = 1'b0;
                end else begin
                    if (hs[r]) begin
                        void'(src_q[r].pop_front());
                        started[r] = 1'b0;
                    end
                    if (!started[r] && src_q[r].size() > 0) begin
                        started[r]  = 1'b1;
                        wait_cnt[r] = int'(src_q[r][0].gap);
                    end
                    if (started[r] && wait_cnt[r] > 0) wait_cnt[r]--;
                end
                req_valid[r] = started[r] && (wait_cnt[r] == 0);
                req_last[r]  = started[r] ? src_q[r][0].last : 1'b0;
                req_data[r*8 +: 8] = started[r] ? src_q[r][0].data : 8'h00;
            end
        end
    end

    // Monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            for (int r = 0; r < N; r++) if (req_ready[r]) ready_n[r]++;
            if (tx_start) begin
                starts_n++;
                if (tx_busy) busy_viol++;
            end
            if (busy && grant != '0 && grant != last_grant) begin
                grant_log.push_back(grant);
                last_grant = grant;
            end
            if (prev_obusy && !busy) begin
                obusy_falls++;
                if (prev_txbusy) order_bad++;
            end
            prev_obusy  = busy;
            prev_txbusy = tx_busy;
            if (!rst_n) begin
                rx_cnt = 0;
            end else if (tx_busy && tx_div == 2) begin
                rx_bits[rx_cnt] = tx_line;
                rx_cnt++;
                if (rx_cnt == 10) begin
                    rx_q.push_back(rx_bits[8:1]);
                    last_frame = rx_bits;
                    rx_cnt = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        vec_t vecs [4];
        int   n;

        vecs[0] = '{r: 0, data: 8'hA5, exp_grant: 4'b0001, exp_byte: 8'hA5};
        vecs[1] = '{r: 2, data: 8'h00, exp_grant: 4'b0100, exp_byte: 8'h00};
        vecs[2] = '{r: 1, data: 8'hFF, exp_grant: 4'b0010, exp_byte: 8'hFF};
        vecs[3] = '{r: 3, data: 8'h3C, exp_grant: 4'b1000, exp_byte: 8'h3C};

        clear_mon();
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_tx_start", 32'(tx_start), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single-byte transactions from individual requesters.
        for (int i = 0; i < 4; i++) begin
            clear_mon();
            push(vecs[i].r, vecs[i].data, 1'b1, 0);
            wait_idle($sformatf("vec%0d", i), 1000);
            check($sformatf("vec%0d_nbytes", i), 32'(rx_q.size()), 32'd1);
            check($sformatf("vec%0d_byte", i), 32'(get_rx(0)), 32'(vecs[i].exp_byte));
            check($sformatf("vec%0d_grant", i), 32'(get_grant(0)), 32'(vecs[i].exp_grant));
            check($sformatf("vec%0d_ready", i), 32'(ready_n[vecs[i].r]), 32'd1);
            check($sformatf("vec%0d_starts", i), 32'(starts_n), 32'd1);
            check($sformatf("vec%0d_busy_order", i), 32'(order_bad), 32'd0);
            if (i == 0) check("vec0_frame", 32'(last_frame), 32'(10'b11_0100_1010));
        end

        // Full contention: strict rotation starting from requester 0.
        clear_mon();
        for (int r = 0; r < N; r++) push(r, 8'(8'h10 + r), 1'b1, 0);
        push(0, 8'h10, 1'b1, 0);
        wait_idle("cont", 2000);
        check("cont_nbytes", 32'(rx_q.size()), 32'd5);
        check("cont_b0", 32'(get_rx(0)), 32'h10);
        check("cont_b1", 32'(get_rx(1)), 32'h11);
        check("cont_b2", 32'(get_rx(2)), 32'h12);
        check("cont_b3", 32'(get_rx(3)), 32'h13);
        check("cont_b4", 32'(get_rx(4)), 32'h10);
        check("cont_start_while_busy", 32'(busy_viol), 32'd0);
        check("cont_grant4", 32'(get_grant(4)), 32'b0001);

        // Packet lock: requester 1's three bytes are not interleaved with 2.
        clear_mon();
        push(1, 8'h01, 1'b0, 0);
        push(1, 8'h02, 1'b0, 0);
        push(1, 8'h03, 1'b1, 0);
        push(2, 8'h20, 1'b1, 0);
        wait_idle("lock", 2000);
        check("lock_b0", 32'(get_rx(0)), 32'h01);
        check("lock_b1", 32'(get_rx(1)), 32'h02);
        check("lock_b2", 32'(get_rx(2)), 32'h03);
        check("lock_b3", 32'(get_rx(3)), 32'h20);
        check("lock_grants", 32'(grant_log.size()), 32'd2);
        check("lock_grant0", 32'(get_grant(0)), 32'b0010);
        check("lock_busy_falls", 32'(obusy_falls), 32'd2);

        // Owner stall: requester 3 pauses mid-packet; requester 0 must wait.
        clear_mon();
        push(3, 8'h30, 1'b0, 0);
        push(3, 8'h31, 1'b1, 50);
        push(0, 8'h40, 1'b1, 0);
        wait_idle("stall", 2000);
        check("stall_b0", 32'(get_rx(0)), 32'h30);
        check("stall_b1", 32'(get_rx(1)), 32'h31);
        check("stall_b2", 32'(get_rx(2)), 32'h40);
        check("stall_grants", 32'(grant_log.size()), 32'd2);
        check("stall_grant0", 32'(get_grant(0)), 32'b1000);
        check("stall_grant1", 32'(get_grant(1)), 32'b0001);
        check("stall_ready0", 32'(ready_n[0]), 32'd1);

        // Timeout: transmitter never goes busy.
        clear_mon();
        stub_mode = 1'b1;
        push(1, 8'h55, 1'b1, 0);
        n = 0;
        while (!tx_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("to_start_seen", 32'(n < 100), 32'd1);
        check("to_err_before", 32'(err), 32'd0);
        @(posedge clk);  // edge that ends the ISSUE cycle
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!err && n < 50);
        check("to_latency", 32'(n), 32'(BUSY_TO));
        check("to_back_to_arb", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        check("to_single_start", 32'(starts_n), 32'd1);
        stub_mode = 1'b0;
        clear_mon();
        push(2, 8'h66, 1'b1, 0);
        wait_idle("after_to", 1000);
        check("after_to_byte", 32'(get_rx(0)), 32'h66);
        check("after_to_ready", 32'(ready_n[2]), 32'd1);
        check("after_to_err_sticky", 32'(err), 32'd1);

        // Asynchronous reset in the middle of a locked packet's frame.
        clear_mon();
        push(0, 8'h77, 1'b0, 0);
        push(0, 8'h78, 1'b1, 0);
        n = 0;
        while (!tx_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ar_tx_busy_seen", 32'(n < 100), 32'd1);
        repeat (10) @(negedge clk);
        check("ar_grant_before", 32'(grant), 32'b0001);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        flush_sources();
        #1;
        check("ar_ready", 32'(req_ready), 32'h0);
        check("ar_grant", 32'(grant), 32'h0);
        check("ar_tx_data", 32'(tx_data), 32'h0);
        check("ar_tx_start", 32'(tx_start), 32'h0);
        check("ar_busy", 32'(busy), 32'h0);
        check("ar_err", 32'(err), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        repeat (5) @(negedge clk);
        check("ar_no_start_on_release", 32'(starts_n), 32'd0);
        check("ar_idle_after_release", 32'(busy), 32'd0);
        push(3, 8'h33, 1'b1, 0);
        push(2, 8'h22, 1'b1, 0);
        wait_idle("ar_fresh", 2000);
        check("ar_b0", 32'(get_rx(0)), 32'h22);
        check("ar_b1", 32'(get_rx(1)), 32'h33);
        check("ar_grant0", 32'(get_grant(0)), 32'b0100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
